// File: rtl/riscv_alu_issue_pkg.sv
// riscv_alu_issue_pkg: ALU command codes, RV32I opcode/funct7 constants and the funct3 map.
package riscv_alu_issue_pkg;

    typedef enum logic [3:0] {
        ALU_NONE             = 4'd0,
        ALU_ADD              = 4'd1,
        ALU_SUB              = 4'd2,
        ALU_SHIFTL           = 4'd3,
        ALU_LESS_THAN_SIGNED = 4'd4,
        ALU_LESS_THAN        = 4'd5,
        ALU_XOR              = 4'd6,
        ALU_SHIFTR           = 4'd7,
        ALU_SHIFTR_ARITH     = 4'd8,
        ALU_OR               = 4'd9,
        ALU_AND              = 4'd10
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Shared by OP and OP-IMM; alt selects SUB / arithmetic right shift.
    function automatic alu_ctrl_e f3_to_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SHIFTL;
            3'b010:  return ALU_LESS_THAN_SIGNED;
            3'b011:  return ALU_LESS_THAN;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SHIFTR_ARITH : ALU_SHIFTR;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// riscv_imm_gen: sign-extended I/S/U immediates and shift amount from an RV32I instruction.
module riscv_imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_u,
    output logic [4:0]      shamt
);

    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    assign shamt = instr[24:20];

endmodule

// File: rtl/riscv_alu_issue.sv
// riscv_alu_issue: RV32I decode/issue stage producing registered ALU commands.
// Define RV_ISSUE_SKID_EN for a one-entry skid buffer with registered in_ready.
module riscv_alu_issue
    import riscv_alu_issue_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit RESET_PC_NOP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_ctrl,
    output logic [XLEN-1:0] out_op_a,
    output logic [XLEN-1:0] out_op_b,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal
);

    typedef struct packed {
        logic [3:0]      alu_ctrl;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } cmd_t;

    localparam cmd_t RST_CMD = RESET_PC_NOP ? cmd_t'({ALU_NONE, {(2*XLEN+7){1'b0}}}) : '0;

    logic [XLEN-1:0] imm_i, imm_s, imm_u;
    logic [4:0]      shamt;
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic            alt, ill, we;
    alu_ctrl_e       ctrl;
    logic [XLEN-1:0] a, b;
    cmd_t            dec, cmd;
    logic            xfer_in;

    riscv_imm_gen #(.XLEN(XLEN)) u_imm (
        .instr (in_instr[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_u (imm_u),
        .shamt (shamt)
    );

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];
    assign alt = f7 == F7_ALT;

    always_comb begin
        ctrl = ALU_ADD;
        a    = in_rs1_data;
        b    = in_rs2_data;
        we   = 1'b1;
        ill  = 1'b0;
        case (opc)
            OPC_OP: begin
                ctrl = f3_to_alu(f3, alt);
                ill  = !(f7 == F7_ZERO || (alt && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                ctrl = f3_to_alu(f3, alt && f3 == 3'b101);
                b    = (f3 == 3'b001 || f3 == 3'b101) ? XLEN'(shamt) : imm_i;
                ill  = f3 == 3'b001 ? f7 != F7_ZERO :
                       f3 == 3'b101 ? !(f7 == F7_ZERO || alt) : 1'b0;
            end
            OPC_LUI: begin
                a = '0;
                b = imm_u;
            end
            OPC_AUIPC: begin
                a = in_pc;
                b = imm_u;
            end
            OPC_LOAD: b = imm_i;
            OPC_STORE: begin
                b  = imm_s;
                we = 1'b0;
            end
            OPC_BRANCH: begin
                we   = 1'b0;
                ctrl = !f3[2] ? ALU_SUB : f3[1] ? ALU_LESS_THAN : ALU_LESS_THAN_SIGNED;
                ill  = f3[2:1] == 2'b01;
            end
            OPC_JAL, OPC_JALR: begin
                a = in_pc;
                b = XLEN'(4);
            end
            default: ill = 1'b1;
        endcase
        dec.alu_ctrl = ill ? ALU_NONE : ctrl;
        dec.op_a     = ill ? '0 : a;
        dec.op_b     = ill ? '0 : b;
        dec.rd       = ill ? 5'd0 : in_instr[11:7];
        dec.rd_we    = !ill && we && in_instr[11:7] != 5'd0;
        dec.illegal  = ill;
    end

    assign xfer_in = in_valid && in_ready;

`ifdef RV_ISSUE_SKID_EN
    logic skid_full;
    cmd_t skid;

    assign in_ready = !skid_full;

    // A decode accepted while the output is stalled parks in the skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            cmd       <= RST_CMD;
            skid_full <= 1'b0;
            skid      <= RST_CMD;
        end else if (out_valid && !out_ready) begin
            if (xfer_in) begin
                skid      <= dec;
                skid_full <= 1'b1;
            end
        end else if (skid_full) begin
            cmd       <= skid;
            out_valid <= 1'b1;
            skid_full <= 1'b0;
        end else if (xfer_in) begin
            cmd       <= dec;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            cmd       <= RST_CMD;
        end else if (xfer_in) begin
            cmd       <= dec;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

    assign out_alu_ctrl = cmd.alu_ctrl;
    assign out_op_a     = cmd.op_a;
    assign out_op_b     = cmd.op_b;
    assign out_rd       = cmd.rd;
    assign out_rd_we    = cmd.rd_we;
    assign out_illegal  = cmd.illegal;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// tb_riscv_alu_issue: directed vector table, back-pressure/reset sequences and a randomized
// scoreboard run against a transaction-level decode model.
module tb_riscv_alu_issue;
    import riscv_alu_issue_pkg::*;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_instr = '0, in_pc = '0, in_rs1_data = '0, in_rs2_data = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [3:0]  out_alu_ctrl;
    logic [31:0] out_op_a, out_op_b;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_illegal;

    int   checks = 0, failures = 0, outs = 0;
    logic s_ov;
    logic prev_stall = 1'b0;
    exp_t held;
    exp_t sbq[$];
    logic [3:0] alu_map [8];

    always #5 clk = ~clk;

    riscv_alu_issue #(.XLEN(32), .RESET_PC_NOP(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_alu_ctrl (out_alu_ctrl),
        .out_op_a     (out_op_a),
        .out_op_b     (out_op_b),
        .out_rd       (out_rd),
        .out_rd_we    (out_rd_we),
        .out_illegal  (out_illegal)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t cur_out();
        return '{out_alu_ctrl, out_op_a, out_op_b, out_rd, out_rd_we, out_illegal};
    endfunction

    // Reference decode written directly from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] ii, si, ui, a, b;
        logic [3:0]  c;
        logic        ok, we;
        f3 = ins[14:12];
        f7 = ins[31:25];
        ii = {{20{ins[31]}}, ins[31:20]};
        si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ui = {ins[31:12], 12'h000};
        a = r1; b = r2; c = ALU_ADD; ok = 1'b1; we = 1'b1;
        case (ins[6:0])
            7'h33: begin
                c = alu_map[f3];
                if (f7 == 7'h20 && f3 == 3'd0) c = ALU_SUB;
                if (f7 == 7'h20 && f3 == 3'd5) c = ALU_SHIFTR_ARITH;
                ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'h13: begin
                c = alu_map[f3];
                b = ii;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    b = {27'd0, ins[24:20]};
                    ok = f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
                    if (f3 == 3'd5 && f7 == 7'h20) c = ALU_SHIFTR_ARITH;
                end
            end
            7'h37: begin a = 32'd0; b = ui; end
            7'h17: begin a = pc; b = ui; end
            7'h03: b = ii;
            7'h23: begin b = si; we = 1'b0; end
            7'h63: begin
                we = 1'b0;
                ok = f3 != 3'd2 && f3 != 3'd3;
                c = f3 < 3'd2 ? ALU_SUB : (f3 < 3'd6 ? ALU_LESS_THAN_SIGNED : ALU_LESS_THAN);
            end
            7'h6f, 7'h67: begin a = pc; b = 32'd4; end
            default: ok = 1'b0;
        endcase
        if (!ok) return '{ALU_NONE, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1};
        return '{c, a, b, ins[11:7], we && ins[11:7] != 5'd0, 1'b0};
    endfunction

    function automatic vec_t mk(input logic [31:0] i, p, r1, r2, input logic [3:0] c,
                                input logic [31:0] a, b, input logic [4:0] rd, input logic we, ill);
        vec_t v;
        v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
        v.e = '{c, a, b, rd, we, ill};
        return v;
    endfunction

    // One cycle: drive at negedge, sample 1ns later, score transfers that occur at the next posedge.
    task automatic step(input logic iv, input logic [31:0] ins, pc, r1, r2, input logic orr,
                        output logic acc);
        exp_t got;
        @(negedge clk);
        in_valid = iv; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
        out_ready = orr;
        #1;
        got  = cur_out();
        s_ov = out_valid;
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_payload", got, held);
        end
`ifndef RV_ISSUE_SKID_EN
        chk("in_ready_comb", in_ready, !out_valid || orr);
`endif
        if (out_valid && orr) begin
            outs++;
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_out: got %0h expected none", got);
            end else begin
                chk("order_payload", got, sbq.pop_front());
            end
        end
        acc = iv && in_ready;
        if (acc) sbq.push_back(model(ins, pc, r1, r2));
        prev_stall = out_valid && !orr;
        held = got;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tv[18];
        logic        acc, got_b;
        int          n, outs0;
        logic [31:0] ci, cp, c1, c2, rnd;
        logic        civ, cor;
        alu_map = '{ALU_ADD, ALU_SHIFTL, ALU_LESS_THAN_SIGNED, ALU_LESS_THAN,
                    ALU_XOR, ALU_SHIFTR, ALU_OR, ALU_AND};

        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_payload", cur_out(), exp_t'({ALU_NONE, 71'd0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        tv[0]  = mk(32'h002081B3, 0, 7, 9, ALU_ADD, 7, 9, 3, 1, 0);
        tv[1]  = mk(32'h00500093, 0, 0, 0, ALU_ADD, 0, 5, 1, 1, 0);
        tv[2]  = mk(32'h402081B3, 0, 20, 5, ALU_SUB, 20, 5, 3, 1, 0);
        tv[3]  = mk(32'h40335293, 0, 32'h80000000, 0, ALU_SHIFTR_ARITH, 32'h80000000, 3, 5, 1, 0);
        tv[4]  = mk(32'h123450B7, 32'h100, 32'hDEAD, 0, ALU_ADD, 0, 32'h12345000, 1, 1, 0);
        tv[5]  = mk(32'h0220C1B3, 0, 1, 2, ALU_NONE, 0, 0, 0, 0, 1);
        tv[6]  = mk(32'h0000007F, 0, 1, 2, ALU_NONE, 0, 0, 0, 0, 1);
        tv[7]  = mk(32'h00000013, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
        tv[8]  = mk(32'h00001097, 32'h1000, 0, 0, ALU_ADD, 32'h1000, 32'h1000, 1, 1, 0);
        tv[9]  = mk(32'hFFF08113, 0, 10, 0, ALU_ADD, 10, 32'hFFFFFFFF, 2, 1, 0);
        tv[10] = mk(32'hFE20AE23, 0, 100, 5, ALU_ADD, 100, 32'hFFFFFFFC, 28, 0, 0);
        tv[11] = mk(32'h0020C063, 0, 3, 4, ALU_LESS_THAN_SIGNED, 3, 4, 0, 0, 0);
        tv[12] = mk(32'h0020F063, 0, 3, 4, ALU_LESS_THAN, 3, 4, 0, 0, 0);
        tv[13] = mk(32'h0020A063, 0, 3, 4, ALU_NONE, 0, 0, 0, 0, 1);
        tv[14] = mk(32'h000000EF, 32'h200, 9, 9, ALU_ADD, 32'h200, 4, 1, 1, 0);
        tv[15] = mk(32'h40109093, 0, 1, 1, ALU_NONE, 0, 0, 0, 0, 1);
        tv[16] = mk(32'h00000011, 0, 1, 1, ALU_NONE, 0, 0, 0, 0, 1);
        tv[17] = mk(32'h4020D1B3, 0, 32'hF0, 4, ALU_SHIFTR_ARITH, 32'hF0, 4, 3, 1, 0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = tv[i].instr; in_pc = tv[i].pc;
            in_rs1_data = tv[i].rs1; in_rs2_data = tv[i].rs2; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_payload", i), cur_out(), tv[i].e);
        end
        repeat (2) @(negedge clk);

        // Back-pressure: A accepted, then B offered while the output stalls.
        outs0 = outs;
        step(1, 32'h002081B3, 0, 7, 9, 0, acc);
        chk("bp_accept_a", acc, 1'b1);
        n = 0; got_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(!got_b, 32'h40335293, 0, 32'h11, 0, 0, acc);
            if (acc) begin n++; got_b = 1'b1; end
        end
`ifdef RV_ISSUE_SKID_EN
        chk("bp_stall_accepts", n, 1);
`else
        chk("bp_stall_accepts", n, 0);
`endif
        for (int i = 0; i < 6; i++) begin
            step(!got_b, 32'h40335293, 0, 32'h11, 0, 1, acc);
            if (acc) got_b = 1'b1;
        end
        chk("bp_b_accepted", got_b, 1'b1);
        chk("bp_outputs", outs - outs0, 2);
        chk("bp_drained", sbq.size(), 0);

        // Reset while an output is stalled.
        step(1, 32'h00500093, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);
        chk("rst_pre_valid", s_ov, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_payload", cur_out(), exp_t'({ALU_NONE, 71'd0}));
        sbq.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h123450B7, 0, 0, 0, 1, acc);
        chk("post_rst_accept", acc, 1'b1);
        step(0, 0, 0, 0, 0, 1, acc);
        chk("post_rst_latency", s_ov, 1'b1);

        // Randomized traffic against the model.
        civ = 1'b0; ci = '0; cp = '0; c1 = '0; c2 = '0;
        for (int i = 0; i < 500; i++) begin
            if (!civ) begin
                ci = $urandom;
                rnd = $urandom;
                case (rnd[1:0])
                    2'd0: ci[31:25] = 7'h00;
                    2'd1: ci[31:25] = 7'h20;
                    default: ;
                endcase
                case (rnd[5:2])
                    4'd0: ci[6:0] = 7'h33;
                    4'd1, 4'd2: ci[6:0] = 7'h13;
                    4'd3: ci[6:0] = 7'h37;
                    4'd4: ci[6:0] = 7'h17;
                    4'd5: ci[6:0] = 7'h03;
                    4'd6: ci[6:0] = 7'h23;
                    4'd7, 4'd8: ci[6:0] = 7'h63;
                    4'd9: ci[6:0] = 7'h6f;
                    4'd10: ci[6:0] = 7'h67;
                    4'd11: ci[6:0] = 7'h33;
                    default: ;
                endcase
                cp = $urandom; c1 = $urandom; c2 = $urandom;
                civ = $urandom_range(0, 3) != 0;
            end
            cor = $urandom_range(0, 9) < 7;
            step(civ, ci, cp, c1, c2, cor, acc);
            if (acc || !civ) civ = 1'b0;
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, acc);
        chk("rand_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
